baud_tick_gen_mc: RTL and testbench

BAUD_TICK_GEN_MC -- requirements
Module: baud_tick_gen_mc

---
 rtl/baud_tick_pkg.sv | 24 ++
 rtl/baud_tick_gen_mc_chan.sv | 76 +++++++
 rtl/baud_tick_gen_mc.sv | 50 +++++
 tb/tb_baud_tick_gen_mc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/baud_tick_pkg.sv
// Shared constants and constant functions for the multi-channel baud tick generator.
package baud_tick_pkg;

  localparam int ACC_W_DEFAULT = 16;
  localparam int OVS_DEFAULT   = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Rounded increment giving baud*ovs ticks per second from a clk_hz clock.
  function automatic longint unsigned calc_inc(input longint unsigned clk_hz,
                                               input longint unsigned baud,
                                               input longint unsigned ovs,
                                               input int              acc_w);
    return (((baud * ovs) << acc_w) + (clk_hz / 2)) / clk_hz;
  endfunction

endpackage

// File: rtl/baud_tick_gen_mc_chan.sv
// One fractional-accumulator tick channel: oversample tick on accumulator carry,
// bit tick on every OVS-th oversample tick, with phase restart and run enable.
module baud_tick_chan
  import baud_tick_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEFAULT,
  parameter int               OVS         = OVS_DEFAULT,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'('h0275)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             os_tick,
  output logic             bit_tick
);

  localparam int               OVS_W    = clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_HALF = OVS_W'(OVS / 2);

  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    sum        = {1'b0, acc_q} + {1'b0, inc_q};
    inc_d      = wr_en ? wr_inc : inc_q;
    acc_d      = acc_q;
    ovs_cnt_d  = ovs_cnt_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    if (!en) begin
      acc_d     = '0;
      ovs_cnt_d = '0;
    end else if (sync) begin
      // Restarting half a bit in puts the first bit tick at mid-bit.
      acc_d     = '0;
      ovs_cnt_d = OVS_HALF;
    end else begin
      acc_d     = sum[ACC_W-1:0];
      os_tick_d = sum[ACC_W];
      if (sum[ACC_W]) begin
        ovs_cnt_d  = ovs_cnt_q + 1'b1;
        bit_tick_d = (ovs_cnt_q == OVS_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      inc_q      <= INC_DEFAULT;
      acc_q      <= '0;
      ovs_cnt_q  <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      inc_q      <= inc_d;
      acc_q      <= acc_d;
      ovs_cnt_q  <= ovs_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;

endmodule

// File: rtl/baud_tick_gen_mc.sv
// Multi-channel baud tick generator: NCH independent channels sharing one
// increment-register write port.
module baud_tick_gen_mc
  import baud_tick_pkg::*;
#(
  parameter int               NCH         = 2,
  parameter int               ACC_W       = ACC_W_DEFAULT,
  parameter int               OVS         = OVS_DEFAULT,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'('h0275),
  localparam int              CH_W        = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic [NCH-1:0]   os_tick,
  output logic [NCH-1:0]   bit_tick
);

  logic [NCH-1:0] wr_en;

  // A select of NCH or above matches no channel, so such writes fall away.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_en[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    baud_tick_chan #(
      .ACC_W       (ACC_W),
      .OVS         (OVS),
      .INC_DEFAULT (INC_DEFAULT)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en[g]),
      .sync     (sync[g]),
      .wr_en    (wr_en[g]),
      .wr_inc   (cfg_inc),
      .os_tick  (os_tick[g]),
      .bit_tick (bit_tick[g])
    );
  end

endmodule

// File: tb/tb_baud_tick_gen_mc.sv
// Directed bench for baud_tick_gen_mc: per-cycle vector table plus long
// sequences checked against a tick-phase model.
module tb_baud_tick_gen_mc;

  // Three channels so that an out-of-range select (3) is encodable on cfg_ch.
  localparam int NCH = 3;
  localparam int OVS = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  en, sync;
  logic            cfg_we;
  logic [1:0]      cfg_ch;
  logic [15:0]     cfg_inc;
  logic [NCH-1:0]  os_tick, bit_tick;

  int n_cmp = 0;
  int n_bad = 0;

  int ph[NCH];
  int boff[NCH];
  int per[NCH];

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic [2:0] sync;
    logic       we;
    logic [1:0] ch;
    logic [15:0] inc;
    logic [2:0] exp_os;
    logic [2:0] exp_bit;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  baud_tick_gen_mc #(.NCH(NCH), .ACC_W(16), .OVS(OVS), .INC_DEFAULT(16'h0275)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .os_tick  (os_tick),
    .bit_tick (bit_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic [2:0] e, input logic [2:0] s,
                     input logic we, input logic [1:0] ch, input logic [15:0] inc,
                     input logic [2:0] eo, input logic [2:0] eb);
    vec_t v;
    v.rst = rst; v.en = e; v.sync = s; v.we = we; v.ch = ch; v.inc = inc;
    v.exp_os = eo; v.exp_bit = eb;
    vecs.push_back(v);
  endtask

  // Model: a channel restarted ph edges ago with period per ticks on every
  // per-th edge; bit ticks fall where the tick count plus offset is a multiple of OVS.
  task automatic run(input int cycles, input string name);
    int  errs;
    logic eo, eb;
    errs = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (reset || !en[c]) begin
          ph[c] = 0; boff[c] = 0;
        end else if (sync[c]) begin
          ph[c] = 0; boff[c] = OVS / 2;
        end else begin
          ph[c]++;
        end
        eo = (ph[c] > 0) && (ph[c] % per[c] == 0);
        eb = eo && (((ph[c] / per[c]) + boff[c]) % OVS == 0);
        if (os_tick[c] !== eo || bit_tick[c] !== eb || (bit_tick[c] && !os_tick[c])) errs++;
      end
    end
    check(name, errs, 0);
  endtask

  initial begin
    int first0, first1, cnt, last, mn, mx, k;

    reset = 1'b0; en = '0; sync = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0;
    for (int c = 0; c < NCH; c++) begin
      ph[c] = 0; boff[c] = 0; per[c] = 16;
    end

    //   rst en    sync  we ch  inc       os     bit
    add(1, 3'b001, 3'b001, 1, 0, 16'hC000, 3'b000, 3'b000); // reset wins
    add(0, 3'b000, 3'b000, 1, 0, 16'hC000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // acc C000
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b001, 3'b000); // 8000 c
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b001, 3'b000); // 4000 c
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b001, 3'b000); // 0000 c
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // C000
    add(0, 3'b001, 3'b000, 1, 0, 16'h0000, 3'b001, 3'b000); // 8000 c, inc<=0
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // stalled
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 1, 0, 16'h8000, 3'b000, 3'b000); // inc<=8000
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b001, 3'b000); // 0000 c
    add(0, 3'b001, 3'b001, 1, 0, 16'h4000, 3'b000, 3'b000); // sync + write
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // 4000
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // 8000
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // C000
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b001, 3'b000); // 0000 c
    add(0, 3'b000, 3'b001, 0, 0, 16'h0000, 3'b000, 3'b000); // sync ignored
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // 4000
    add(0, 3'b001, 3'b000, 1, 3, 16'hFFFF, 3'b000, 3'b000); // 8000, ch3 ignored
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // C000
    add(0, 3'b001, 3'b000, 0, 0, 16'h0000, 3'b001, 3'b000); // 0000 c
    add(0, 3'b001, 3'b000, 1, 1, 16'hFFFF, 3'b000, 3'b000); // ch1 inc<=FFFF
    add(0, 3'b011, 3'b000, 0, 0, 16'h0000, 3'b000, 3'b000); // ch1 FFFF
    add(0, 3'b011, 3'b000, 0, 0, 16'h0000, 3'b010, 3'b000); // ch1 FFFE c
    add(0, 3'b011, 3'b000, 0, 0, 16'h0000, 3'b011, 3'b000); // both carry
    add(0, 3'b011, 3'b000, 0, 0, 16'h0000, 3'b010, 3'b000);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; en = vecs[i].en; sync = vecs[i].sync;
      cfg_we = vecs[i].we; cfg_ch = vecs[i].ch; cfg_inc = vecs[i].inc;
      tick();
      check($sformatf("vec%0d os_tick", i), 32'(os_tick), 32'(vecs[i].exp_os));
      check($sformatf("vec%0d bit_tick", i), 32'(bit_tick), 32'(vecs[i].exp_bit));
    end

    reset = 1'b1; en = '0; sync = '0; cfg_we = 1'b0;
    tick();
    reset = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h1000;
    run(1, "cfg ch0 while idle");
    cfg_we = 1'b0;
    per[0] = 16;

    // T1: ch0 os every 16 clk, bit every 256 clk.
    en = 3'b001;
    run(600, "T1 ch0 0x1000 pattern");

    // T4: ch1 written and enabled alongside running ch0, then an out-of-range write.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'h2000;
    run(1, "T4 write ch1");
    cfg_we = 1'b0;
    per[1] = 8;
    en = 3'b011;
    run(300, "T4 ch0 16 / ch1 8 spacing");
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'hFFFF;
    run(1, "T4 write ch3");
    cfg_we = 1'b0;
    run(300, "T4 unchanged after ch3 write");

    // T3: sync on the cycle ch0 would have carried.
    k = 15 - (ph[0] % 16);
    if (k > 0) run(k, "T3 align");
    sync = 3'b001;
    run(1, "T3 sync edge suppresses tick");
    sync = '0;
    run(400, "T3 mid-bit restart");

    // T6: one-cycle enable drop on ch0.
    en = 3'b010;
    run(1, "T6 en low");
    en = 3'b011;
    run(300, "T6 resume");

    // T5: reset mid-count with enables held high.
    reset = 1'b1;
    run(3, "T5 outputs during reset");
    reset = 1'b0;
    first0 = 0; first1 = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (os_tick[0] && first0 == 0) first0 = n;
      if (os_tick[1] && first1 == 0) first1 = n;
    end
    check("T5 ch0 first tick after release", first0, 105);
    check("T5 ch1 first tick after release", first1, 105);

    // T2: non-power-of-two increment 0x5555 over 3000 clk.
    en = '0;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h5555;
    tick();
    cfg_we = 1'b0;
    en = 3'b001;
    cnt = 0; last = 0; mn = 1000; mx = 0;
    for (int n = 1; n <= 3000; n++) begin
      tick();
      if (os_tick[0]) begin
        if (cnt > 0) begin
          if (n - last < mn) mn = n - last;
          if (n - last > mx) mx = n - last;
        end
        cnt++;
        last = n;
      end
    end
    check("T2 tick count is 999 or 1000", 32'(cnt == 999 || cnt == 1000), 1);
    check("T2 spacing within 3..4", 32'(mn >= 3 && mx <= 4), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
